// File: rtl/cmlink_tx_framer.sv
// Camera Link Base/Medium/Full word framer. Sources are DVP passthrough, a ramp/flat test
// pattern generator, or mute. Mode changes only take effect on frame boundaries.
module cmlink_tx_framer #(
   parameter int N_CHIP   = 1,
   parameter int H_ACTIVE = 1280,
   parameter int H_BLANK  = 64,
   parameter int V_ACTIVE = 1024,
   parameter int V_BLANK  = 16,
   localparam int NPORT   = (N_CHIP == 3) ? 8 : 3 * N_CHIP
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [1:0]            i_mode,
   input  logic                  i_fvld,
   input  logic                  i_lvld,
   input  logic                  i_dvld,
   input  logic [8*NPORT-1:0]    i_data,
   output logic [28*N_CHIP-1:0]  o_cm_data,
   output logic [1:0]            o_mode,
   output logic [15:0]           o_frame_cnt,
   output logic                  o_sync_err
);
   localparam int VB_CYC = V_BLANK * (H_ACTIVE + H_BLANK);
   localparam int CW     = $clog2(VB_CYC + 1);
   localparam int YW     = $clog2(V_ACTIVE + 1);
   localparam int TW     = 24 * N_CHIP;
   localparam int OW     = 28 * N_CHIP;

   localparam logic [1:0] MODE_PASS = 2'd0;
   localparam logic [1:0] MODE_RAMP = 2'd1;
   localparam logic [1:0] MODE_FLAT = 2'd2;

   typedef enum logic [1:0] {
      ST_VBLANK = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_HBLANK = 2'd2
   } gen_state_e;

   // Channel-Link TxIN ordering for one chip fed by ports P/Q/R.
   function automatic logic [27:0] map_chip(input logic [7:0] p, input logic [7:0] q,
                                            input logic [7:0] r, input logic lval,
                                            input logic fval, input logic dval);
      logic [27:0] w;
      w[4:0]   = p[4:0];
      w[5]     = p[7];
      w[6]     = p[5];
      w[9:7]   = q[2:0];
      w[10]    = q[6];
      w[11]    = q[7];
      w[14:12] = q[5:3];
      w[15]    = r[0];
      w[16]    = r[6];
      w[17]    = r[7];
      w[22:18] = r[5:1];
      w[23]    = 1'b0;
      w[24]    = lval;
      w[25]    = fval;
      w[26]    = dval;
      w[27]    = p[6];
      return w;
   endfunction

   gen_state_e         gen_state_q, gen_state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [YW-1:0]      y_q, y_d;
   logic [7:0]         fidx_q, fidx_d;
   logic [1:0]         mode_q, mode_d;
   logic [OW-1:0]      cm_data_q, cm_data_d;
   logic [15:0]        frame_cnt_q, frame_cnt_d;
   logic               sync_err_q, sync_err_d;

   logic               gen_run_s, mode_load_s, gen_restart_s;
   logic               gen_fval_s, gen_active_s;
   logic               src_fval_s, src_lval_s, src_dval_s;
   logic [8*NPORT-1:0] taps_s;
   logic [TW-1:0]      taps_pad_s;

   // Generator state register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         gen_state_q <= ST_VBLANK;
      end else begin
         gen_state_q <= gen_state_d;
      end
   end

   // Pending mode request is only accepted at a boundary of the source currently in effect.
   always_comb begin
      gen_run_s = (mode_q == MODE_RAMP) || (mode_q == MODE_FLAT);
      case (mode_q)
         MODE_PASS:            mode_load_s = ~i_fvld;
         MODE_RAMP, MODE_FLAT: mode_load_s = (gen_state_q == ST_VBLANK);
         default:              mode_load_s = 1'b1;
      endcase
      gen_restart_s = mode_load_s && (i_mode != mode_q) &&
                      ((i_mode == MODE_RAMP) || (i_mode == MODE_FLAT));
      mode_d = mode_load_s ? i_mode : mode_q;
   end

   // Generator next state; cnt_q doubles as x during ACTIVE.
   always_comb begin
      gen_state_d = gen_state_q;
      cnt_d       = cnt_q;
      y_d         = y_q;
      fidx_d      = fidx_q;
      if (gen_restart_s) begin
         gen_state_d = ST_VBLANK;
         cnt_d       = '0;
         y_d         = '0;
         fidx_d      = 8'd0;
      end else if (gen_run_s) begin
         case (gen_state_q)
            ST_VBLANK: begin
               if (cnt_q == CW'(VB_CYC - 1)) begin
                  gen_state_d = ST_ACTIVE;
                  cnt_d       = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            ST_ACTIVE: begin
               if (cnt_q == CW'(H_ACTIVE - 1)) begin
                  gen_state_d = ST_HBLANK;
                  cnt_d       = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            ST_HBLANK: begin
               if (cnt_q != CW'(H_BLANK - 1)) begin
                  cnt_d = cnt_q + CW'(1);
               end else if (y_q == YW'(V_ACTIVE - 1)) begin
                  gen_state_d = ST_VBLANK;
                  cnt_d       = '0;
                  y_d         = '0;
                  fidx_d      = fidx_q + 8'd1;
               end else begin
                  gen_state_d = ST_ACTIVE;
                  cnt_d       = '0;
                  y_d         = y_q + YW'(1);
               end
            end
            default: begin
               gen_state_d = ST_VBLANK;
               cnt_d       = '0;
               y_d         = '0;
            end
         endcase
      end else begin
         gen_state_d = gen_state_q;
      end
   end

   // Generator sync outputs.
   always_comb begin
      case (gen_state_q)
         ST_ACTIVE: begin
            gen_fval_s   = 1'b1;
            gen_active_s = 1'b1;
         end
         ST_HBLANK: begin
            gen_fval_s   = 1'b1;
            gen_active_s = 1'b0;
         end
         default: begin
            gen_fval_s   = 1'b0;
            gen_active_s = 1'b0;
         end
      endcase
   end

   // Source select, chip mapping, frame counting and sync checking.
   always_comb begin
      taps_s     = '0;
      src_fval_s = 1'b0;
      src_lval_s = 1'b0;
      src_dval_s = 1'b0;
      case (mode_q)
         MODE_PASS: begin
            taps_s     = i_data;
            src_fval_s = i_fvld;
            src_lval_s = i_lvld;
            src_dval_s = i_dvld;
         end
         MODE_RAMP: begin
            src_fval_s = gen_fval_s;
            src_lval_s = gen_active_s;
            src_dval_s = gen_active_s;
            for (int p = 0; p < NPORT; p++) begin
               if (gen_active_s) begin
                  taps_s[8*p +: 8] = 8'(cnt_q) + 8'(y_q) + fidx_q + 8'(p);
               end else begin
                  taps_s[8*p +: 8] = 8'h00;
               end
            end
         end
         MODE_FLAT: begin
            src_fval_s = gen_fval_s;
            src_lval_s = gen_active_s;
            src_dval_s = gen_active_s;
            for (int p = 0; p < NPORT; p++) begin
               if (gen_active_s) begin
                  taps_s[8*p +: 8] = 8'h80;
               end else begin
                  taps_s[8*p +: 8] = 8'h00;
               end
            end
         end
         default: taps_s = '0;
      endcase
      // Full mode has no port for chip 2 slot R; zero padding supplies it.
      taps_pad_s = TW'(taps_s);
      cm_data_d  = '0;
      for (int k = 0; k < N_CHIP; k++) begin
         cm_data_d[28*k +: 28] = map_chip(taps_pad_s[24*k +: 8], taps_pad_s[24*k+8 +: 8],
                                          taps_pad_s[24*k+16 +: 8],
                                          src_lval_s, src_fval_s, src_dval_s);
      end
      frame_cnt_d = frame_cnt_q + {15'd0, cm_data_d[25] & ~cm_data_q[25]};
      sync_err_d  = sync_err_q | ((mode_q == MODE_PASS) &&
                    ((i_lvld & ~i_fvld) | (i_dvld & ~i_lvld)));
   end

   // Datapath and status registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_q       <= '0;
         y_q         <= '0;
         fidx_q      <= 8'd0;
         mode_q      <= 2'd0;
         cm_data_q   <= '0;
         frame_cnt_q <= 16'd0;
         sync_err_q  <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         y_q         <= y_d;
         fidx_q      <= fidx_d;
         mode_q      <= mode_d;
         cm_data_q   <= cm_data_d;
         frame_cnt_q <= frame_cnt_d;
         sync_err_q  <= sync_err_d;
      end
   end

   assign o_cm_data   = cm_data_q;
   assign o_mode      = mode_q;
   assign o_frame_cnt = frame_cnt_q;
   assign o_sync_err  = sync_err_q;
endmodule
